// File: rtl/dvfs_pstate_ctrl.sv
// dvfs_pstate_ctrl: P-state governor with hysteresis/dwell filtering and a
// voltage/frequency sequencer that talks to the regulator over v_req/v_ack.
// Raising the P-state moves the voltage first and then the frequency. Lowering
// it moves the frequency first and then the voltage, so f_sel never runs ahead
// of an acknowledged voltage.
module dvfs_pstate_ctrl #(
    parameter int LOAD_W      = 8,
    parameter int UP_THRESH   = 192,
    parameter int DOWN_THRESH = 64,
    parameter int DWELL       = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [LOAD_W-1:0] load,
    input  logic              force_en,
    input  logic [1:0]        force_pstate,
    input  logic              v_ack,
    output logic              v_req,
    output logic [1:0]        v_target,
    output logic [1:0]        f_sel,
    output logic [1:0]        pstate,
    output logic              busy,
    output logic              fault
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LOAD_W-1:0] UP_LVL  = LOAD_W'(UP_THRESH);
    localparam logic [LOAD_W-1:0] DN_LVL  = LOAD_W'(DOWN_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DWELL);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        V_UP = 3'd1,
        F_UP = 3'd2,
        F_DN = 3'd3,
        V_DN = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] up_cnt, up_nx;
    logic [CNT_W-1:0] dn_cnt, dn_nx;
    logic [TO_W-1:0]  to_cnt, to_nx;
    logic [1:0]       target, target_nx;
    logic             v_req_nx;
    logic [1:0]       v_target_nx;
    logic [1:0]       f_sel_nx;
    logic [1:0]       pstate_nx;
    logic             fault_nx;
    logic             go;
    logic             is_high;
    logic             is_low;

    // Next-state logic: sample filtering and step decisions in IDLE, and the
    // voltage/frequency ordering plus ack timeout while a change is in flight.
    always_comb begin
        state_nx    = state;
        up_nx       = up_cnt;
        dn_nx       = dn_cnt;
        to_nx       = to_cnt;
        target_nx   = target;
        v_req_nx    = v_req;
        v_target_nx = v_target;
        f_sel_nx    = f_sel;
        pstate_nx   = pstate;
        fault_nx    = fault;
        go          = 1'b0;
        is_high     = (load >= UP_LVL);
        is_low      = (load <= DN_LVL);

        case (state)
            IDLE: begin
                to_nx = '0;
                if (force_en) begin
                    if (force_pstate != pstate) begin
                        go        = 1'b1;
                        target_nx = force_pstate;
                    end
                end else if (up_cnt == CNT_MAX && pstate != 2'd3) begin
                    go        = 1'b1;
                    target_nx = pstate + 2'd1;
                end else if (dn_cnt == CNT_MAX && pstate != 2'd0) begin
                    go        = 1'b1;
                    target_nx = pstate - 2'd1;
                end else if (load_valid) begin
                    if (is_high) begin
                        if (up_cnt != CNT_MAX) up_nx = up_cnt + 1'b1;
                        dn_nx = '0;
                    end else if (is_low) begin
                        if (dn_cnt != CNT_MAX) dn_nx = dn_cnt + 1'b1;
                        up_nx = '0;
                    end else begin
                        up_nx = '0;
                        dn_nx = '0;
                    end
                end
                if (go) begin
                    up_nx = '0;
                    dn_nx = '0;
                    if (target_nx > pstate) begin
                        state_nx    = V_UP;
                        v_req_nx    = 1'b1;
                        v_target_nx = target_nx;
                    end else begin
                        state_nx = F_DN;
                    end
                end
            end
            V_UP: begin
                if (v_ack) begin
                    v_req_nx = 1'b0;
                    state_nx = F_UP;
                end else if (to_cnt == TO_LAST) begin
                    v_req_nx = 1'b0;
                    fault_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    to_nx = to_cnt + 1'b1;
                end
            end
            F_UP: begin
                f_sel_nx  = target;
                pstate_nx = target;
                state_nx  = IDLE;
            end
            F_DN: begin
                f_sel_nx    = target;
                v_req_nx    = 1'b1;
                v_target_nx = target;
                to_nx       = '0;
                state_nx    = V_DN;
            end
            V_DN: begin
                if (v_ack) begin
                    pstate_nx = target;
                    v_req_nx  = 1'b0;
                    state_nx  = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    pstate_nx = target;
                    v_req_nx  = 1'b0;
                    fault_nx  = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    to_nx = to_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything to zero immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            to_cnt   <= '0;
            target   <= '0;
            v_req    <= 1'b0;
            v_target <= '0;
            f_sel    <= '0;
            pstate   <= '0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            up_cnt   <= up_nx;
            dn_cnt   <= dn_nx;
            to_cnt   <= to_nx;
            target   <= target_nx;
            v_req    <= v_req_nx;
            v_target <= v_target_nx;
            f_sel    <= f_sel_nx;
            pstate   <= pstate_nx;
            busy     <= (state_nx != IDLE);
            fault    <= fault_nx;
        end
    end

endmodule

// File: tb/tb_dvfs_pstate_ctrl.sv
// tb_dvfs_pstate_ctrl: scoreboard bench for the P-state governor. Stimulus
// pushes the expected regulator request and completion for every P-state
// change predicted by a sample-streak model. A monitor pops and compares those
// expectations whenever v_req rises or busy falls.
module tb_dvfs_pstate_ctrl;

    localparam int LOAD_W      = 8;
    localparam int UP_THRESH   = 192;
    localparam int DOWN_THRESH = 64;
    localparam int DWELL       = 16;
    localparam int ACK_TIMEOUT = 1023;

    typedef struct {
        int v_target;
        int f_sel;
        int pstate;
        int gap;
    } req_t;

    typedef struct {
        int pstate;
        int fault;
        int latency;
        int timeout;
    } done_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic [LOAD_W-1:0] load;
    logic              force_en;
    logic [1:0]        force_pstate;
    logic              v_ack;
    logic              resp_ack;
    logic              late_ack;
    logic              v_req;
    logic [1:0]        v_target;
    logic [1:0]        f_sel;
    logic [1:0]        pstate;
    logic              busy;
    logic              fault;

    int tests_run    = 0;
    int tests_failed = 0;
    int m_pstate, m_fault, m_up, m_dn;
    int ack_enable = 1;
    int ack_delay  = 2;
    req_t  req_q[$];
    done_t done_q[$];

    assign v_ack = resp_ack | late_ack;

    dvfs_pstate_ctrl #(
        .LOAD_W(LOAD_W), .UP_THRESH(UP_THRESH), .DOWN_THRESH(DOWN_THRESH),
        .DWELL(DWELL), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load(load),
        .force_en(force_en), .force_pstate(force_pstate), .v_ack(v_ack),
        .v_req(v_req), .v_target(v_target), .f_sel(f_sel), .pstate(pstate),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_v_req"}, int'(v_req), 0);
        checkOutput({tag, "_v_target"}, int'(v_target), 0);
        checkOutput({tag, "_f_sel"}, int'(f_sel), 0);
        checkOutput({tag, "_pstate"}, int'(pstate), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_fault"}, int'(fault), 0);
    endtask

    task automatic modelReset();
        m_pstate = 0;
        m_fault  = 0;
        m_up     = 0;
        m_dn     = 0;
        req_q.delete();
        done_q.delete();
    endtask

    // Predict one P-state change toward tgt under the current ack behaviour.
    task automatic expectStep(input int tgt);
        req_t  r;
        done_t d;
        bit    up;
        up         = (tgt > m_pstate);
        r.v_target = tgt;
        r.f_sel    = up ? m_pstate : tgt;
        r.pstate   = m_pstate;
        r.gap      = up ? 0 : 1;
        if (ack_enable != 0) begin
            d.pstate  = tgt;
            d.fault   = m_fault;
            d.latency = up ? 1 : 0;
            d.timeout = 0;
        end else begin
            d.pstate  = up ? m_pstate : tgt;
            d.fault   = 1;
            d.latency = -1;
            d.timeout = 1;
        end
        req_q.push_back(r);
        done_q.push_back(d);
        m_pstate = d.pstate;
        m_fault  = d.fault;
        m_up     = 0;
        m_dn     = 0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checkOutput("busy_rise_timeout", int'(busy), 1);
            return;
        end
        n = 0;
        while (busy && n < ACK_TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("busy_fall_timeout", int'(busy), 0);
    endtask

    // One utilization sample; the streak model decides whether a step follows.
    task automatic applyStimulus(input int ld);
        int tgt;
        tgt = -1;
        if (ld >= UP_THRESH) begin
            m_up = (m_up < DWELL) ? m_up + 1 : DWELL;
            m_dn = 0;
        end else if (ld <= DOWN_THRESH) begin
            m_dn = (m_dn < DWELL) ? m_dn + 1 : DWELL;
            m_up = 0;
        end else begin
            m_up = 0;
            m_dn = 0;
        end
        if (m_up == DWELL && m_pstate < 3) tgt = m_pstate + 1;
        else if (m_dn == DWELL && m_pstate > 0) tgt = m_pstate - 1;
        if (tgt >= 0) expectStep(tgt);
        load_valid = 1'b1;
        load       = LOAD_W'(ld);
        @(negedge clk);
        load_valid = 1'b0;
        if (tgt >= 0) begin
            waitIdle();
            @(negedge clk);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic forceTo(input int tgt);
        force_pstate = 2'(tgt);
        if (tgt != m_pstate) begin
            expectStep(tgt);
            force_en = 1'b1;
            @(negedge clk);
            force_en = 1'b0;
            waitIdle();
        end else begin
            force_en = 1'b1;
            repeat (2) @(negedge clk);
            force_en = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic int pickLoad(input int cls);
        int v;
        if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
                0:       v = UP_THRESH - 1;
                1:       v = UP_THRESH;
                2:       v = DOWN_THRESH;
                default: v = DOWN_THRESH + 1;
            endcase
        end else if (cls <= 4) begin
            v = $urandom_range(UP_THRESH, 255);
        end else if (cls <= 8) begin
            v = $urandom_range(0, DOWN_THRESH);
        end else begin
            v = $urandom_range(DOWN_THRESH + 1, UP_THRESH - 1);
        end
        return v;
    endfunction

    // Regulator model: acknowledges a held v_req after ack_delay cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        resp_ack = 1'b0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (v_req && !rst && ack_enable != 0) begin
                if (wait_cnt >= ack_delay) begin
                    resp_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares DUT events against the scoreboard queues.
    initial begin
        logic       p_vreq, p_busy;
        logic [1:0] p_fsel;
        int         since_ack, gap, vreq_cnt, acked;
        req_t       r;
        done_t      d;
        p_vreq = 1'b0; p_busy = 1'b0; p_fsel = 2'd0;
        since_ack = -1; gap = 0; vreq_cnt = 0; acked = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                p_vreq = 1'b0; p_busy = 1'b0; p_fsel = 2'd0;
                since_ack = -1; acked = 0;
            end else begin
                if (p_vreq && v_ack) begin
                    since_ack = 0;
                    acked     = int'(v_target);
                end else if (since_ack >= 0) begin
                    since_ack++;
                end
                if (busy && !p_busy) begin
                    gap = 0; vreq_cnt = 0; since_ack = -1;
                end else if (busy) begin
                    gap++;
                end
                if (v_req) vreq_cnt++;
                if (f_sel != p_fsel) begin
                    tests_run++;
                    if (int'(f_sel) > acked) begin
                        tests_failed++;
                        $display("[TB] FAIL fsel_above_voltage: got f_sel %0d, acked level %0d", f_sel, acked);
                    end
                end
                if (v_req && !p_vreq) begin
                    if (req_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_v_req: got v_target %0d, expected no request", v_target);
                    end else begin
                        r = req_q.pop_front();
                        checkOutput("req_v_target", int'(v_target), r.v_target);
                        checkOutput("req_f_sel", int'(f_sel), r.f_sel);
                        checkOutput("req_pstate", int'(pstate), r.pstate);
                        checkOutput("req_busy_gap", gap, r.gap);
                    end
                end
                if (!busy && p_busy) begin
                    if (done_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_done: got pstate %0d, expected no transition", pstate);
                    end else begin
                        d = done_q.pop_front();
                        checkOutput("done_pstate", int'(pstate), d.pstate);
                        checkOutput("done_f_sel", int'(f_sel), d.pstate);
                        checkOutput("done_fault", int'(fault), d.fault);
                        checkOutput("done_ack_latency", since_ack, d.latency);
                        if (d.timeout != 0) checkOutput("timeout_req_cycles", vreq_cnt, ACK_TIMEOUT);
                    end
                end
                p_vreq = v_req;
                p_busy = busy;
                p_fsel = f_sel;
            end
        end
    end

    // Directed scenarios followed by randomized bursts.
    initial begin
        int n, cls, len;
        rst = 1'b1; load_valid = 1'b0; load = '0;
        force_en = 1'b0; force_pstate = 2'd0; late_ack = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        $display("[TB] T2: dwell of high samples from pstate 0");
        ack_enable = 1; ack_delay = 3;
        repeat (DWELL) applyStimulus(200);
        checkOutput("t2_pstate", int'(pstate), 1);
        checkOutput("t2_f_sel", int'(f_sel), 1);
        checkOutput("t2_busy", int'(busy), 0);

        $display("[TB] T3: broken streak and saturation at top");
        repeat (DWELL - 1) applyStimulus(200);
        applyStimulus(100);
        repeat (DWELL - 1) applyStimulus(200);
        repeat (6) @(negedge clk);
        checkOutput("t3_pstate_hold", int'(pstate), 1);
        ack_delay = 2;
        forceTo(3);
        repeat (40) applyStimulus(255);
        repeat (4) @(negedge clk);
        checkOutput("t3_pstate_top", int'(pstate), 3);

        $display("[TB] T4: down step from pstate 2");
        forceTo(2);
        ack_delay = 1;
        repeat (DWELL) applyStimulus(10);
        checkOutput("t4_pstate", int'(pstate), 1);

        $display("[TB] T5: ack withheld on up step");
        ack_enable = 0;
        repeat (DWELL) applyStimulus(200);
        checkOutput("t5_fault", int'(fault), 1);
        checkOutput("t5_pstate", int'(pstate), 1);
        checkOutput("t5_v_req", int'(v_req), 0);
        ack_enable = 1;

        $display("[TB] T6: forced jump with samples during sequence");
        forceTo(0);
        ack_delay = 8;
        force_pstate = 2'd3;
        expectStep(3);
        force_en = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy && n < ACK_TIMEOUT + 50) begin
            load_valid = (n < 12);
            load       = LOAD_W'(10);
            @(negedge clk);
            n++;
        end
        load_valid = 1'b0;
        checkOutput("t6_pstate", int'(pstate), 3);
        force_en = 1'b0;
        @(negedge clk);
        ack_delay = 2;
        repeat (DWELL - 1) applyStimulus(10);
        repeat (4) @(negedge clk);
        checkOutput("t6_no_early_down", int'(pstate), 3);
        applyStimulus(10);
        checkOutput("t6_down_after_dwell", int'(pstate), 2);

        $display("[TB] T1: reset in the middle of a voltage raise");
        ack_enable = 0;
        expectStep(3);
        force_pstate = 2'd3;
        force_en = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        n = 0;
        while (!v_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!v_req) checkOutput("t1_v_req_timeout", int'(v_req), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("t1_in_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (4) @(negedge clk);
        checkAllZero("t1_after_late_ack");
        ack_enable = 1;

        $display("[TB] random bursts");
        for (int b = 0; b < 30; b++) begin
            ack_enable = ($urandom_range(0, 11) != 0) ? 1 : 0;
            ack_delay  = $urandom_range(0, 6);
            if ($urandom_range(0, 5) == 0) forceTo($urandom_range(0, 3));
            cls = $urandom_range(0, 9);
            len = $urandom_range(4, 20);
            for (int i = 0; i < len; i++) applyStimulus(pickLoad(cls));
        end
        repeat (6) @(negedge clk);
        checkOutput("final_pstate", int'(pstate), m_pstate);
        checkOutput("final_fault", int'(fault), m_fault);
        checkOutput("req_queue_left", req_q.size(), 0);
        checkOutput("done_queue_left", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
